// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM/owner types and default parameters for the two-requester APB arbiter
package apb_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;
    typedef enum logic {OWN_M0, OWN_M1} owner_t;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational 2-way round-robin pick (req0/req1/last_grant -> grant_valid/grant_id)
module apb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant_id
);
    assign grant_valid = req0 | req1;
    assign grant_id    = (req0 & req1) ? (last_grant == OWN_M0 ? OWN_M1 : OWN_M0) : (req1 ? OWN_M1 : OWN_M0);
endmodule

// File: rtl/apb_arbiter2.sv
// apb_arbiter2: shares one APB slave (PSEL/PENABLE/PADDR/PWRITE/PWDATA, PRDATA/PREADY) between req/done requesters m0 and m1
module apb_arbiter2
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    state_t        state, state_n;
    owner_t        owner, last_grant, grant_id;
    logic          grant_valid, ok, abort;
    logic [CW-1:0] cnt;
    apb_rr_pick u_pick (
        .req0        (m0_req & ~m0_done),
        .req1        (m1_req & ~m1_done),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );
    always_comb begin
        ok      = state == ST_ACCESS && PREADY;
        abort   = state == ST_ACCESS && !PREADY && cnt == CNT_LAST;
        state_n = state == ST_IDLE  ? (grant_valid ? ST_SETUP : ST_IDLE) :
                  state == ST_SETUP ? ST_ACCESS :
                  (ok || abort)     ? ST_IDLE : ST_ACCESS;
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            owner      <= OWN_M0;
            last_grant <= OWN_M1;
            cnt        <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            m0_rdata   <= '0;
            m0_done    <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= '0;
            m1_done    <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            state   <= state_n;
            m0_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_done <= 1'b0;
            m1_err  <= 1'b0;
            if (state == ST_IDLE && grant_valid) begin
                owner      <= grant_id;
                last_grant <= grant_id;
                PSEL       <= 1'b1;
                PADDR      <= grant_id == OWN_M1 ? m1_addr  : m0_addr;
                PWRITE     <= grant_id == OWN_M1 ? m1_write : m0_write;
                PWDATA     <= grant_id == OWN_M1 ? m1_wdata : m0_wdata;
            end
            if (state == ST_SETUP) begin
                PENABLE <= 1'b1;
                cnt     <= '0;
            end
            if (state == ST_ACCESS && !PREADY) cnt <= cnt + CW'(1);
            if (ok || abort) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                if (owner == OWN_M0) begin
                    m0_done <= 1'b1;
                    m0_err  <= abort;
                    if (abort) m0_rdata <= '0;
                    else if (!PWRITE) m0_rdata <= PRDATA;
                end else begin
                    m1_done <= 1'b1;
                    m1_err  <= abort;
                    if (abort) m1_rdata <= '0;
                    else if (!PWRITE) m1_rdata <= PRDATA;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_arbiter2.sv
// tb_apb_arbiter2: directed + randomized checks of apb_arbiter2 against a GPIO-like slave and a transaction-level model
module tb_apb_arbiter2;
    localparam int TO = 16;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [3:0]  m0_addr = '0, m1_addr = '0;
    logic        m0_write = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done, m0_err, m1_err;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic [31:0] gpio_in = '0;
    int          slave_mode = 0;
    int          checks = 0, errors = 0;
    logic [31:0] exp_mem [4];
    logic [31:0] exp_rd [2];
    int          mdl_last = 1;
    logic        rdy_q;
    logic [31:0] smem [4];

    always #5 PCLK = ~PCLK;

    apb_arbiter2 #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // GPIO-like slave: word regs CR/IDR/ODR, IDR reads gpio_in; mode 0 zero-wait, 1 one-wait, 2 never ready
    assign PREADY = slave_mode == 0 ? 1'b1 : slave_mode == 1 ? rdy_q : 1'b0;
    assign PRDATA = PADDR[3:2] == 2'd1 ? gpio_in : smem[PADDR[3:2]];
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rdy_q <= 1'b0;
            for (int i = 0; i < 4; i++) smem[i] <= '0;
        end else begin
            rdy_q <= PSEL && PENABLE && !rdy_q;
            if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR[3:2]] <= PWDATA;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) exp_mem[i] = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        mdl_last = 1;
    endtask

    task automatic set_m(input int m, input logic r, input logic [3:0] a, input logic w, input logic [31:0] d);
        if (m == 0) begin
            m0_req = r; m0_addr = a; m0_write = w; m0_wdata = d;
        end else begin
            m1_req = r; m1_addr = a; m1_write = w; m1_wdata = d;
        end
    endtask

    function automatic logic [31:0] rd_of(input int m);
        return m == 0 ? m0_rdata : m1_rdata;
    endfunction
    function automatic logic done_of(input int m);
        return m == 0 ? m0_done : m1_done;
    endfunction
    function automatic logic err_of(input int m);
        return m == 0 ? m0_err : m1_err;
    endfunction

    // transaction-level outcome of one completed transfer
    task automatic predict(input int m, input logic [3:0] a, input logic w, input logic [31:0] d, input logic to, output logic e);
        e = to;
        if (to) exp_rd[m] = '0;
        else if (w) exp_mem[a[3:2]] = d;
        else exp_rd[m] = a[3:2] == 2'd1 ? gpio_in : exp_mem[a[3:2]];
        mdl_last = m;
    endtask

    task automatic xfer(input int m, input logic [3:0] a, input logic w, input logic [31:0] d, input int md);
        int n;
        logic e;
        logic [31:0] other_rd;
        slave_mode = md;
        @(negedge PCLK);
        set_m(m, 1'b1, a, w, d);
        other_rd = rd_of(1 - m);
        n = 0;
        while (!done_of(m) && n < 60) begin
            @(posedge PCLK);
            #1;
            n++;
            if (n == 1) begin
                chk("setup_phase", {PSEL, PENABLE}, 2'b10);
                set_m(m, 1'b1, ~a, ~w, ~d);
            end
            if (n == 2) chk("access_latched", {PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, w, a, d});
            chk("other_static", {done_of(1 - m), err_of(1 - m), rd_of(1 - m)}, {2'b00, other_rd});
        end
        predict(m, a, w, d, md == 2, e);
        chk("latency", n, md == 0 ? 3 : md == 1 ? 4 : TO + 2);
        chk("err", err_of(m), e);
        chk("rdata", rd_of(m), exp_rd[m]);
        @(posedge PCLK);
        #1;
        chk("idle_gap", {PSEL, done_of(m)}, 2'b00);
        set_m(m, 1'b0, a, w, d);
    endtask

    task automatic both_held(input int k);
        logic [3:0]  a [2];
        logic        w [2];
        logic [31:0] d [2];
        int want, who, n;
        logic e;
        slave_mode = 1;
        @(negedge PCLK);
        for (int i = 0; i < 2; i++) begin
            a[i] = {2'($urandom_range(0, 3)), 2'b00};
            w[i] = 1'($urandom_range(0, 1));
            d[i] = $urandom;
            set_m(i, 1'b1, a[i], w[i], d[i]);
        end
        want = 0;
        for (int t = 0; t < k; t++) begin
            want = 1 - mdl_last;
            who = -1;
            n = 0;
            while (who < 0 && n < 20) begin
                @(posedge PCLK);
                #1;
                n++;
                if (m0_done || m1_done) begin
                    chk("tie_single_done", m0_done & m1_done, 0);
                    who = m0_done ? 0 : 1;
                end
            end
            chk("tie_winner", who, want);
            chk("tie_interval", n, 4);
            predict(want, a[want], w[want], d[want], 1'b0, e);
            chk("tie_err", err_of(want), e);
            chk("tie_rdata", rd_of(want), exp_rd[want]);
            a[want] = {2'($urandom_range(0, 3)), 2'b00};
            w[want] = 1'($urandom_range(0, 1));
            d[want] = $urandom;
            set_m(want, 1'b1, a[want], w[want], d[want]);
        end
        set_m(0, 1'b0, a[0], w[0], d[0]);
        set_m(1, 1'b0, a[1], w[1], d[1]);
        @(posedge PCLK);
        #1;
        chk("tie_drain", PSEL, 0);
    endtask

    initial begin
        int n;
        reset_model();
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_ctrl", {PSEL, PENABLE, PWRITE, m0_done, m1_done, m0_err, m1_err}, 0);
        chk("reset_data", {PADDR, PWDATA, m0_rdata, m1_rdata}, 0);
        @(negedge PCLK);
        PRESET = 1'b0;

        xfer(0, 4'h0, 1'b1, 32'h0000_00FF, 1);
        xfer(0, 4'h8, 1'b1, 32'h0000_00A5, 1);
        chk("gpio_pins", smem[2], 32'h0000_00A5);
        xfer(0, 4'h0, 1'b1, 32'h0, 1);
        gpio_in = 32'h0000_003C;
        xfer(1, 4'h4, 1'b0, 32'h1234_5678, 1);
        chk("m1_idr", m1_rdata, 32'h0000_003C);
        xfer(0, 4'h8, 1'b0, 32'h0, 0);

        xfer(0, 4'h8, 1'b0, 32'h0, 2);
        xfer(0, 4'h8, 1'b0, 32'h0, 1);
        chk("after_timeout", m0_rdata, 32'h0000_00A5);

        slave_mode = 2;
        @(negedge PCLK);
        set_m(1, 1'b1, 4'h4, 1'b0, 32'h0);
        repeat (4) @(posedge PCLK);
        #1;
        chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        set_m(1, 1'b0, 4'h0, 1'b0, 32'h0);
        #1;
        chk("midrst_ctrl", {PSEL, PENABLE, PWRITE, m0_done, m1_done, m0_err, m1_err}, 0);
        chk("midrst_data", {PADDR, PWDATA, m0_rdata, m1_rdata}, 0);
        reset_model();
        @(negedge PCLK);
        PRESET = 1'b0;
        n = 0;
        repeat (25) begin
            @(posedge PCLK);
            #1;
            if (PSEL || m0_done || m1_done) n++;
        end
        chk("no_abandoned_done", n, 0);

        gpio_in = $urandom;
        both_held(8);

        for (int i = 0; i < 20; i++) begin
            int md;
            md = $urandom_range(0, 5);
            gpio_in = $urandom;
            xfer(int'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), 2'b00}, 1'($urandom_range(0, 1)),
                 $urandom, md < 3 ? 0 : md < 5 ? 1 : 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
